// File: rtl/cmd_sequencer.sv
// cmd_sequencer: replays a small command memory to RemoteComm, one command at
// a time, waiting for each ack (or timeout) and keeping sticky status.
module cmd_sequencer #(
  parameter int          DEPTH        = 8,
  parameter int          TIMEOUT_CYC  = 1000000,
  parameter logic [7:0]  POS_ACK      = 8'hA5,
  parameter bit          ABORT_ON_ERR = 1'b1,
  localparam int         AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW:0]   num_cmds,
  input  logic          start,
  output logic [15:0]   cmd,
  output logic          snd_cmd,
  input  logic          cmd_snt,
  input  logic          resp_rdy,
  input  logic [7:0]    resp,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW-1:0] err_idx,
  output logic [AW:0]   ack_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  // Expiry fires on the wait cycle whose increment lands on TIMEOUT_CYC-1.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_SNT, WAIT_RESP, FIN} state_e;

  state_e        state_q, state_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          snd_q, snd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic [AW-1:0] eidx_q, eidx_d;
  logic [AW:0]   ack_q, ack_d;
  logic [AW:0]   n_q, n_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   mem_q [DEPTH];

  logic [TW-1:0] tmo_inc;
  logic [AW-1:0] idx_nx;
  logic          more;

  assign tmo_inc = tmo_q + TW'(1);
  assign idx_nx  = idx_q + AW'(1);
  assign more    = ({1'b0, idx_q} + (AW+1)'(1)) < n_q;

  // Command memory: loadable only while idle, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && state_q == IDLE) mem_q[wr_addr] <= wr_data;
  end

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    snd_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;
    eidx_d  = eidx_q;
    ack_d   = ack_q;
    n_d     = n_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d    = (num_cmds > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_cmds;
          done_d = 1'b0;
          err_d  = 1'b0;
          code_d = 2'b00;
          eidx_d = '0;
          ack_d  = '0;
          idx_d  = '0;
          tmo_d  = '0;
          busy_d = 1'b1;
          if (n_d == '0) begin
            state_d = FIN;
          end else begin
            state_d = SEND;
            cmd_d   = mem_q[0];
            snd_d   = 1'b1;
          end
        end
      end
      SEND: state_d = WAIT_SNT;
      WAIT_SNT, WAIT_RESP: begin
        tmo_d = tmo_inc;
        if (state_q == WAIT_RESP && resp_rdy) begin
          // A response always beats a coincident timeout.
          if (resp != POS_ACK) begin
            err_d = 1'b1;
            if (code_q == 2'b00) begin
              code_d = 2'b01;
              eidx_d = idx_q;
            end
          end else begin
            ack_d = ack_q + (AW+1)'(1);
          end
          if (resp != POS_ACK && ABORT_ON_ERR) begin
            state_d = FIN;
          end else if (more) begin
            state_d = SEND;
            idx_d   = idx_nx;
            cmd_d   = mem_q[idx_nx];
            snd_d   = 1'b1;
            tmo_d   = '0;
          end else begin
            state_d = FIN;
          end
        end else if (tmo_inc == TMO_LAST) begin
          err_d   = 1'b1;
          if (code_q == 2'b00) begin
            code_d = 2'b10;
            eidx_d = idx_q;
          end
          state_d = FIN;
        end else if (state_q == WAIT_SNT && cmd_snt) begin
          state_d = WAIT_RESP;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= 16'h0000;
      snd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      eidx_q  <= '0;
      ack_q   <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      snd_q   <= snd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      eidx_q  <= eidx_d;
      ack_q   <= ack_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
    end
  end

  assign cmd      = cmd_q;
  assign snd_cmd  = snd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign err_idx  = eidx_q;
  assign ack_cnt  = ack_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: two instances (abort / continue on error) share
// stimulus; a responder plays RemoteComm and scoreboards every sent command.
`timescale 1ns/1ps
module tb_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;      // 0: abort instance, 1: continue instance
  logic        wr_both = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [3:0]  num_cmds = '0;
  logic        start = 1'b0;
  logic        cmd_snt = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = '0;

  logic [15:0] cmd_a, cmd_c, cmd_o;
  logic        snd_a, snd_c, snd_o, busy_a, busy_c, busy_o;
  logic        done_a, done_c, done_o, err_a, err_c, err_o;
  logic [1:0]  code_a, code_c, code_o;
  logic [2:0]  eidx_a, eidx_c, eidx_o;
  logic [3:0]  ack_a, ack_c, ack_o;

  always #5 clk = ~clk;

  cmd_sequencer #(.DEPTH(8), .TIMEOUT_CYC(100), .POS_ACK(8'hA5), .ABORT_ON_ERR(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en & (wr_both | ~sel)), .wr_addr(wr_addr),
    .wr_data(wr_data), .num_cmds(num_cmds), .start(start & ~sel), .cmd(cmd_a),
    .snd_cmd(snd_a), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp),
    .busy(busy_a), .done(done_a), .err(err_a), .err_code(code_a),
    .err_idx(eidx_a), .ack_cnt(ack_a));

  cmd_sequencer #(.DEPTH(8), .TIMEOUT_CYC(100), .POS_ACK(8'hA5), .ABORT_ON_ERR(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en & (wr_both | sel)), .wr_addr(wr_addr),
    .wr_data(wr_data), .num_cmds(num_cmds), .start(start & sel), .cmd(cmd_c),
    .snd_cmd(snd_c), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp),
    .busy(busy_c), .done(done_c), .err(err_c), .err_code(code_c),
    .err_idx(eidx_c), .ack_cnt(ack_c));

  assign cmd_o  = sel ? cmd_c  : cmd_a;
  assign snd_o  = sel ? snd_c  : snd_a;
  assign busy_o = sel ? busy_c : busy_a;
  assign done_o = sel ? done_c : done_a;
  assign err_o  = sel ? err_c  : err_a;
  assign code_o = sel ? code_c : code_a;
  assign eidx_o = sel ? eidx_c : eidx_a;
  assign ack_o  = sel ? ack_c  : ack_a;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int nsnd = 0;
  int last_snd_cyc = 0;
  logic [15:0] exp_q[$];
  logic [8:0]  rsp_q[$];     // bit 8 = respond at all, [7:0] = byte
  logic [15:0] mem_m [8] = '{16'h4004, 16'h47F2, 16'h1234, 16'h2345,
                             16'h3456, 16'h4567, 16'h5678, 16'h6789};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // RemoteComm model: pops the expected word on every send, then acks per script.
  initial begin : responder
    logic [8:0] r;
    forever begin
      @(negedge clk);
      if (snd_o === 1'b1) begin
        nsnd++;
        last_snd_cyc = cyc;
        if (exp_q.size() == 0) chk("extra_snd", 1, 0);
        else chk("cmd_word", cmd_o, exp_q.pop_front());
        r = (rsp_q.size() != 0) ? rsp_q.pop_front() : 9'h000;
        @(posedge clk); #1 cmd_snt = 1'b1;
        @(posedge clk); #1 cmd_snt = 1'b0;
        if (r[8]) begin
          @(posedge clk); #1 resp = r[7:0]; resp_rdy = 1'b1;
          @(posedge clk); #1 resp_rdy = 1'b0;
        end
      end
    end
  end

  task automatic prep(input int nexp, input logic [8:0] r0, input logic [8:0] r1,
                      input logic [8:0] r2);
    exp_q.delete();
    rsp_q.delete();
    for (int i = 0; i < nexp; i++) exp_q.push_back(mem_m[i]);
    rsp_q.push_back(r0);
    rsp_q.push_back(r1);
    rsp_q.push_back(r2);
  endtask

  // Pulse start and wait (bounded) for done; d_cyc = cycles from start to done.
  task automatic run(input bit s, input int n, input bit poke, output int d_cyc);
    int  start_cyc;
    bit  poked;
    bit  seen;
    poked = 1'b0;
    seen  = 1'b0;
    d_cyc = -1;
    sel   = s;
    nsnd  = 0;
    @(posedge clk); #1 num_cmds = 4'(n); start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        seen  = 1'b1;
        d_cyc = cyc - start_cyc;
      end else if (poke && !poked && nsnd >= 1) begin
        poked = 1'b1;
        @(posedge clk); #1 wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        num_cmds = 4'd0; start = 1'b1;
        @(posedge clk); #1 wr_en = 1'b0; start = 1'b0;
      end
    end
    if (!seen) chk("done_wait", 0, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin : main
    int d;
    bit got;
    #2;
    // Reset values
    chk("rst_cmd", cmd_a, 16'h0000);
    chk("rst_snd", snd_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_code", code_a, 0);
    chk("rst_eidx", eidx_a, 0);
    chk("rst_ack", ack_a, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Load both memories
    wr_both = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 wr_en = 1'b1; wr_addr = 3'(i); wr_data = mem_m[i];
    end
    @(posedge clk); #1 wr_en = 1'b0; wr_both = 1'b0;

    // Two commands, both acked
    prep(2, 9'h1A5, 9'h1A5, 9'h000);
    run(1'b0, 2, 1'b0, d);
    chk("t1_nsnd", nsnd, 2);
    chk("t1_done", done_o, 1);
    chk("t1_busy", busy_o, 0);
    chk("t1_ack", ack_o, 2);
    chk("t1_err", err_o, 0);
    chk("t1_code", code_o, 0);
    chk("t1_sb", exp_q.size(), 0);

    // Abort on second-response nack
    prep(2, 9'h1A5, 9'h15A, 9'h1A5);
    run(1'b0, 3, 1'b0, d);
    chk("t2_nsnd", nsnd, 2);
    chk("t2_err", err_o, 1);
    chk("t2_code", code_o, 1);
    chk("t2_eidx", eidx_o, 1);
    chk("t2_ack", ack_o, 1);
    chk("t2_done", done_o, 1);
    chk("t2_sb", exp_q.size(), 0);

    // Same stimulus, continue-on-error instance
    prep(3, 9'h1A5, 9'h15A, 9'h1A5);
    run(1'b1, 3, 1'b0, d);
    chk("t3_nsnd", nsnd, 3);
    chk("t3_err", err_o, 1);
    chk("t3_code", code_o, 1);
    chk("t3_eidx", eidx_o, 1);
    chk("t3_ack", ack_o, 2);
    chk("t3_done", done_o, 1);
    chk("t3_sb", exp_q.size(), 0);

    // Two nacks: only the first is recorded
    prep(3, 9'h15A, 9'h1A5, 9'h100);
    run(1'b1, 3, 1'b0, d);
    chk("t3b_nsnd", nsnd, 3);
    chk("t3b_eidx", eidx_o, 0);
    chk("t3b_code", code_o, 1);
    chk("t3b_ack", ack_o, 1);

    // Timeout: FIN 100 cycles after SEND, done visible one cycle later
    prep(1, 9'h000, 9'h000, 9'h000);
    run(1'b0, 1, 1'b0, d);
    chk("t4_nsnd", nsnd, 1);
    chk("t4_lat", cyc - last_snd_cyc, 101);
    chk("t4_code", code_o, 2);
    chk("t4_eidx", eidx_o, 0);
    chk("t4_err", err_o, 1);
    chk("t4_ack", ack_o, 0);

    // Zero commands
    prep(0, 9'h000, 9'h000, 9'h000);
    run(1'b0, 0, 1'b0, d);
    chk("t5_nsnd", nsnd, 0);
    chk("t5_lat", d, 2);
    chk("t5_code", code_o, 0);

    // Nine requested, clamped to eight; write and start while busy are ignored
    exp_q.delete();
    rsp_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mem_m[i]);
      rsp_q.push_back(9'h1A5);
    end
    run(1'b0, 9, 1'b1, d);
    chk("t6_nsnd", nsnd, 8);
    chk("t6_ack", ack_o, 8);
    chk("t6_err", err_o, 0);
    chk("t6_sb", exp_q.size(), 0);

    // Reset during WAIT_RESP of command 1
    prep(2, 9'h1A5, 9'h000, 9'h000);
    sel = 1'b0;
    nsnd = 0;
    @(posedge clk); #1 num_cmds = 4'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (nsnd >= 2) got = 1'b1;
    end
    if (!got) chk("t7_wait", 0, 1);
    repeat (5) @(negedge clk);
    chk("t7_busy_pre", busy_a, 1);
    rst_n = 1'b0;
    #2;
    chk("t7_cmd", cmd_a, 16'h0000);
    chk("t7_snd", snd_a, 0);
    chk("t7_busy", busy_a, 0);
    chk("t7_done", done_a, 0);
    chk("t7_err", err_a, 0);
    chk("t7_code", code_a, 0);
    chk("t7_eidx", eidx_a, 0);
    chk("t7_ack", ack_a, 0);
    chk("t7_sb", exp_q.size(), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Restart from idx 0, memory intact
    prep(2, 9'h1A5, 9'h1A5, 9'h000);
    run(1'b0, 2, 1'b0, d);
    chk("t8_nsnd", nsnd, 2);
    chk("t8_ack", ack_o, 2);
    chk("t8_sb", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
